// File: rtl/frogger_pkg.sv
// Shared types and playfield constants for the frogger game blocks.
package frogger_pkg;

    typedef enum logic [1:0] {
        PLAY,
        AT_TOP,
        DEAD
    } frog_state_t;

    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer for one raw key pin followed by a rising-edge detector.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // One pulse per press; a held key keeps prev_q high and never re-fires.
    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/frog_mover.sv
// Turns direction key presses into clamped one-cell frog moves and tracks the
// play / reached-top / dead-and-respawning lifecycle of the frog.
module frog_mover
    import frogger_pkg::*;
#(
    parameter int ROWS           = GRID_ROWS,
    parameter int COLS           = GRID_COLS,
    parameter int START_COL      = 7,
    parameter int RESPAWN_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_up,
    input  logic                     key_down,
    input  logic                     key_left,
    input  logic                     key_right,
    input  logic                     hit,
    input  logic                     mid_reset,
    output logic [$clog2(ROWS)-1:0]  frog_row,
    output logic [$clog2(COLS)-1:0]  frog_col,
    output logic                     frog_visible,
    output logic                     frog_reached_top
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(RESPAWN_CYCLES + 1);

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_START = CW'(START_COL);
    localparam logic [NW-1:0] CNT_LOAD  = NW'(RESPAWN_CYCLES - 1);

    frog_state_t   state_q, state_d;
    logic [RW-1:0] row_q,   row_d;
    logic [CW-1:0] col_q,   col_d;
    logic [NW-1:0] cnt_q,   cnt_d;

    logic up_p, down_p, left_p, right_p;

    key_edge u_key_up    (.clk(clk), .reset(reset), .raw(key_up),    .pulse(up_p));
    key_edge u_key_down  (.clk(clk), .reset(reset), .raw(key_down),  .pulse(down_p));
    key_edge u_key_left  (.clk(clk), .reset(reset), .raw(key_left),  .pulse(left_p));
    key_edge u_key_right (.clk(clk), .reset(reset), .raw(key_right), .pulse(right_p));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;

        if (mid_reset) begin
            state_d = PLAY;
            row_d   = ROW_LAST;
            col_d   = COL_START;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    // Only the highest-priority edge is considered; a clamped one is simply dropped.
                    if (hit) begin
                        state_d = DEAD;
                        cnt_d   = CNT_LOAD;
                    end else if (up_p) begin
                        if (row_q != '0) begin
                            row_d = row_q - RW'(1);
                            if (row_q == RW'(1)) state_d = AT_TOP;
                        end
                    end else if (down_p) begin
                        if (row_q != ROW_LAST) row_d = row_q + RW'(1);
                    end else if (left_p) begin
                        if (col_q != '0) col_d = col_q - CW'(1);
                    end else if (right_p) begin
                        if (col_q != COL_LAST) col_d = col_q + CW'(1);
                    end
                end
                AT_TOP: begin
                end
                DEAD: begin
                    if (cnt_q == '0) begin
                        state_d = PLAY;
                        row_d   = ROW_LAST;
                        col_d   = COL_START;
                    end else begin
                        cnt_d = cnt_q - NW'(1);
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
            row_q   <= ROW_LAST;
            col_q   <= COL_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frog_row         = row_q;
    assign frog_col         = col_q;
    assign frog_visible     = (state_q != DEAD);
    assign frog_reached_top = (state_q == AT_TOP);

endmodule
